tile_seq: RTL and testbench

Lane sequencer for the piano-tiles game: decides which of the four lanes carries the next falling tile and when a new row is issued. Sits directly upstream of the pixel generator and drives its `state` (active-lane mask) and `st_chng` (row-restart pulse) inputs. Row timing is derived from the VGA scan coordinates, and the sequencer speeds up as rows accumulate.

---
 rtl/tiles_pkg.sv | 26 ++
 rtl/tile_seq_lfsr16.sv | 18 +
 rtl/tile_seq.sv | 131 +++++++++++++
 tb/tb_tile_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiles_pkg.sv
// Shared constants, lane type, one-hot helper and sequencer state encoding
// for the piano-tiles lane sequencer.
package tiles_pkg;

  localparam int unsigned NUM_LANES = 4;

  // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  function automatic logic [NUM_LANES-1:0] onehot4(input lane_t l);
    logic [NUM_LANES-1:0] v;
    v    = '0;
    v[l] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tile_seq_lfsr16.sv
// 16-bit Galois LFSR used as the lane-choice entropy source; advances on step.
module lfsr16
  import tiles_pkg::*;
(
  input  logic        clk_d,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst)
      q <= LFSR_SEED;
    else if (step)
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/tile_seq.sv
// Lane sequencer: picks the lane of each new tile row and paces row issue
// from VGA frame ticks, shortening the row period as rows accumulate.
module tile_seq
  import tiles_pkg::*;
#(
  parameter int unsigned PERIOD_INIT  = 150,
  parameter int unsigned PERIOD_MIN   = 40,
  parameter int unsigned PERIOD_STEP  = 10,
  parameter int unsigned SPEEDUP_ROWS = 8,
  parameter bit          NO_REPEAT    = 1'b1
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       run,
  output logic [3:0] state,
  output logic       st_chng,
  output logic [9:0] row_count,
  output logic [7:0] period
);

  localparam logic [7:0] P_INIT   = 8'(PERIOD_INIT);
  localparam logic [7:0] P_MIN    = 8'(PERIOD_MIN);
  localparam logic [7:0] P_STEP   = 8'(PERIOD_STEP);
  localparam logic [8:0] P_FLOOR  = {1'b0, P_MIN} + {1'b0, P_STEP};
  localparam logic [9:0] SPD_LAST = 10'(SPEEDUP_ROWS - 1);
  localparam logic [9:0] RC_MAX   = 10'd1023;

  seq_state_t  fsm;
  logic        at00, at00_q, ft;
  logic [15:0] lfsr_q;
  logic        lfsr_step;
  logic        lfsr_unused;
  lane_t       cand, lane, last_lane;
  logic [7:0]  frame_cnt;
  logic [9:0]  spd_cnt;
  logic        issue, rc_sat, speedup;
  logic [7:0]  period_dec;
  logic [3:0]  new_state;

  assign at00 = (pixel_x == '0) && (pixel_y == '0);

  // One tick per frame regardless of how long (0,0) is held
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      at00_q <= 1'b0;
      ft     <= 1'b0;
    end else begin
      at00_q <= at00;
      ft     <= at00 & ~at00_q;
    end
  end

  lfsr16 u_lfsr (
    .clk_d (clk_d),
    .rst   (rst),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:2];

  always_comb begin
    cand = lfsr_q[1:0];
    lane = cand;
    if (NO_REPEAT && (cand == last_lane))
      lane = cand + 2'd1;
    new_state = onehot4(lane);

    issue = 1'b0;
    if (run && ft) begin
      case (fsm)
        ARM:     issue = 1'b1;
        RUN:     issue = (frame_cnt == period - 8'd1);
        default: issue = 1'b0;
      endcase
    end

    // Idle time before start feeds entropy; in play only row issues advance it
    lfsr_step = (fsm == IDLE) || issue;

    rc_sat     = (row_count == RC_MAX);
    speedup    = issue && !rc_sat && (spd_cnt == SPD_LAST);
    period_dec = ({1'b0, period} >= P_FLOOR) ? (period - P_STEP) : P_MIN;
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= '0;
      st_chng   <= 1'b0;
      row_count <= '0;
      period    <= P_INIT;
      frame_cnt <= '0;
      spd_cnt   <= '0;
      last_lane <= '0;
    end else begin
      st_chng <= 1'b0;
      if (!run) begin
        fsm       <= IDLE;
        state     <= '0;
        st_chng   <= (state != '0);
        row_count <= '0;
        period    <= P_INIT;
        frame_cnt <= '0;
        spd_cnt   <= '0;
      end else begin
        case (fsm)
          IDLE:    fsm <= ARM;
          ARM:     if (ft) fsm <= RUN;
          RUN:     if (ft) frame_cnt <= issue ? '0 : frame_cnt + 8'd1;
          default: fsm <= IDLE;
        endcase

        if (issue) begin
          state     <= new_state;
          st_chng   <= (new_state != state);
          last_lane <= lane;
          if (!rc_sat) begin
            row_count <= row_count + 10'd1;
            spd_cnt   <= (spd_cnt == SPD_LAST) ? '0 : spd_cnt + 10'd1;
          end
          if (speedup)
            period <= period_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_seq.sv
// Directed bench for tile_seq: four instances with different parameters share
// one stimulus stream; a per-row monitor checks lanes, spacing and speed-up.
module tb_tile_seq;

  logic       clk_d = 1'b0;
  logic       rst   = 1'b1;
  logic [9:0] pixel_x = 10'd5;
  logic [9:0] pixel_y = 10'd0;
  logic       run   = 1'b0;

  logic [3:0] st  [4];
  logic       chg [4];
  logic [9:0] rcw [4];
  logic [7:0] per [4];

  localparam int P_INIT [4] = '{150, 3, 50, 3};
  localparam int P_MIN  [4] = '{40, 1, 40, 1};
  localparam int P_STEP [4] = '{10, 1, 10, 1};
  localparam int SPD    [4] = '{8, 8, 8, 8};
  localparam int NOREP  [4] = '{1, 1, 1, 0};

  // Lane sequence from seed ACE1 after exactly one idle step
  localparam logic [3:0] SEQ_NR [8] = '{4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h1};
  localparam logic [3:0] SEQ_RP [8] = '{4'h1, 4'h1, 4'h1, 4'h4, 4'h8, 4'h8, 4'h2, 4'h1};
  localparam logic       CHG_RP [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk_d = ~clk_d;

  tile_seq u_d0 (.clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .run(run),
                 .state(st[0]), .st_chng(chg[0]), .row_count(rcw[0]), .period(per[0]));
  tile_seq #(.PERIOD_INIT(3), .PERIOD_MIN(1), .PERIOD_STEP(1), .SPEEDUP_ROWS(8), .NO_REPEAT(1'b1))
    u_d1 (.clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .run(run),
          .state(st[1]), .st_chng(chg[1]), .row_count(rcw[1]), .period(per[1]));
  tile_seq #(.PERIOD_INIT(50), .PERIOD_MIN(40), .PERIOD_STEP(10), .SPEEDUP_ROWS(8), .NO_REPEAT(1'b1))
    u_d2 (.clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .run(run),
          .state(st[2]), .st_chng(chg[2]), .row_count(rcw[2]), .period(per[2]));
  tile_seq #(.PERIOD_INIT(3), .PERIOD_MIN(1), .PERIOD_STEP(1), .SPEEDUP_ROWS(8), .NO_REPEAT(1'b0))
    u_d3 (.clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .run(run),
          .state(st[3]), .st_chng(chg[3]), .row_count(rcw[3]), .period(per[3]));

  typedef struct {
    logic       x00;
    logic       run;
    logic [3:0] s1;
    logic       c1;
    int         rc1;
    logic [3:0] s3;
    logic       c3;
  } vec_t;

  vec_t tbl [19];

  int errs = 0;
  int n_chk = 0;
  int frame_no = 0;
  logic last_x00 = 1'b0;
  logic mon_en = 1'b0;

  int         prev_rc  [4];
  logic [3:0] prev_st  [4];
  logic       prev_chg [4];
  int         pm       [4];
  logic [3:0] lanes    [4];
  int         last_fr  [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int r;
    for (int i = 0; i < 4; i++) begin
      if (!mon_en) begin
        prev_rc[i] = 0; prev_st[i] = '0; prev_chg[i] = 1'b0;
        pm[i] = P_INIT[i]; lanes[i] = '0; last_fr[i] = 0;
      end else begin
        if (chg[i])
          chk($sformatf("d%0d_chg_width", i), int'(prev_chg[i]), 0);
        if (int'(rcw[i]) != prev_rc[i]) begin
          r = int'(rcw[i]);
          chk($sformatf("d%0d_rc_inc", i), r, prev_rc[i] + 1);
          chk($sformatf("d%0d_onehot", i), int'($onehot(st[i])), 1);
          if (NOREP[i] != 0) begin
            chk($sformatf("d%0d_chg_on_issue", i), int'(chg[i]), 1);
            if (r > 1)
              chk($sformatf("d%0d_no_repeat", i), int'(st[i] == prev_st[i]), 0);
          end
          if (r > 1)
            chk($sformatf("d%0d_interval_row%0d", i, r), frame_no - last_fr[i], pm[i]);
          if (r % SPD[i] == 0)
            pm[i] = (pm[i] >= P_MIN[i] + P_STEP[i]) ? pm[i] - P_STEP[i] : P_MIN[i];
          chk($sformatf("d%0d_period_row%0d", i, r), int'(per[i]), pm[i]);
          if (i == 1 && r <= 8)
            chk($sformatf("d1_lane_row%0d", r), int'(st[i]), int'(SEQ_NR[r-1]));
          if (i == 3 && r <= 8) begin
            chk($sformatf("d3_lane_row%0d", r), int'(st[i]), int'(SEQ_RP[r-1]));
            chk($sformatf("d3_chg_row%0d", r), int'(chg[i]), int'(CHG_RP[r-1]));
          end
          lanes[i]   = lanes[i] | st[i];
          last_fr[i] = frame_no;
          prev_st[i] = st[i];
        end
        prev_rc[i]  = int'(rcw[i]);
        prev_chg[i] = chg[i];
      end
    end
  endtask

  // Drive one cycle of stimulus at negedge, sample #1 after the next posedge
  task automatic cyc(input logic x00, input logic r);
    @(negedge clk_d);
    rst     = 1'b0;
    pixel_x = x00 ? 10'd0 : 10'd5;
    pixel_y = 10'd0;
    run     = r;
    if (x00 && !last_x00) frame_no++;
    last_x00 = x00;
    @(posedge clk_d);
    #1;
    monitor();
  endtask

  task automatic frame();
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int chg_hits;
    tbl[0]  = '{1'b0, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1, 4'h1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'h2, 1'b0, 1, 4'h1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'h1, 1'b1, 2, 4'h1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 4'h1, 1'b0, 2, 4'h1, 1'b0};

    // Reset values, then three idle frames with run low
    repeat (2) @(negedge clk_d);
    chk("rst_d0_period", int'(per[0]), 150);
    chk("rst_d0_state", int'(st[0]), 0);
    chg_hits = 0;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        cyc(c == 0, 1'b0);
        for (int i = 0; i < 4; i++) chg_hits += int'(chg[i]);
      end
    chk("idle_chg_hits", chg_hits, 0);
    chk("idle_d0_state", int'(st[0]), 0);
    chk("idle_d0_period", int'(per[0]), 150);
    chk("idle_d0_rc", int'(rcw[0]), 0);

    // Reset with run already high so the LFSR sees exactly one idle step
    @(negedge clk_d);
    rst = 1'b1;
    run = 1'b1;
    pixel_x = 10'd5;
    last_x00 = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 19; k++) begin
      cyc(tbl[k].x00, tbl[k].run);
      chk($sformatf("tbl%0d_d1_state", k), int'(st[1]), int'(tbl[k].s1));
      chk($sformatf("tbl%0d_d1_chg", k), int'(chg[1]), int'(tbl[k].c1));
      chk($sformatf("tbl%0d_d1_rc", k), int'(rcw[1]), tbl[k].rc1);
      chk($sformatf("tbl%0d_d3_state", k), int'(st[3]), int'(tbl[k].s3));
      chk($sformatf("tbl%0d_d3_chg", k), int'(chg[3]), int'(tbl[k].c3));
    end

    // Long run: d2 needs 48 rows; d1 saturates its row counter along the way
    for (int f = 0; f < 2500 && rcw[2] < 10'd48; f++) frame();
    chk("d2_rows_reached", int'(rcw[2]), 48);
    chk("d2_period_clamped", int'(per[2]), 40);
    chk("d1_all_lanes", int'(lanes[1]), 15);
    chk("d1_rc_saturated", int'(rcw[1]), 1023);
    chk("d1_period_floor", int'(per[1]), 1);

    // Drop run on the cycle whose frame tick would issue a row
    mon_en = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("drop_d1_state", int'(st[1]), 0);
    chk("drop_d1_chg", int'(chg[1]), 1);
    chk("drop_d2_chg", int'(chg[2]), 1);
    cyc(1'b0, 1'b0);
    chk("drop_d1_chg_once", int'(chg[1]), 0);
    chk("drop_d1_rc", int'(rcw[1]), 0);
    chk("drop_d1_period", int'(per[1]), 3);
    chk("drop_d0_period", int'(per[0]), 150);

    // Restart: counters from idle values, first row two cycles after (0,0)
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("restart_d1_pre_rc", int'(rcw[1]), 0);
    cyc(1'b0, 1'b1);
    chk("restart_d1_rc", int'(rcw[1]), 1);
    chk("restart_d1_onehot", int'($onehot(st[1])), 1);
    chk("restart_d1_chg", int'(chg[1]), 1);

    // Asynchronous reset mid-game
    @(negedge clk_d);
    #2 rst = 1'b1;
    #1;
    chk("arst_d1_state", int'(st[1]), 0);
    chk("arst_d1_chg", int'(chg[1]), 0);
    chk("arst_d1_rc", int'(rcw[1]), 0);
    chk("arst_d1_period", int'(per[1]), 3);
    chk("arst_d0_period", int'(per[0]), 150);
    cyc(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
